axi4_m512_pkt_fifo: RTL and testbench

AXI4_M512_PKT_FIFO -- requirements
Module: axi4_m512_pkt_fifo

---
 rtl/axi4_m512_pkt_fifo.sv | 199 +++++++++++++++++++
 tb/tb_axi4_m512_pkt_fifo.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_m512_pkt_fifo.sv
// ----------------------------------------------------------------------------
// axi4_m512_pkt_fifo
//   Store-and-forward packet FIFO between a 512-bit upstream beat source and
//   an AXI4 write master. Beats are written speculatively at wptr. They become
//   readable only when the packet's eop beat commits them (cptr advances), so
//   the read side never sees a partial packet.
//
//   Optional feature macro: AXI4_M512_PKT_ERR_DROP_EN
//     defined   : a packet whose eop beat carries err=1 is discarded
//                 (wptr rewinds to cptr) and pkt_drop_cnt_en pulses.
//     undefined : error packets are committed with entry bit 518 set.
//
//   Handshake: the upstream side is valid/ready. A beat transfers on a rising
//   edge of clkr where ul2fifo_vld & fifo2ul_rdy. fifo2ul_rdy never depends on
//   ul2fifo_* inputs. The read side is show-ahead: fifo2axi_rdata holds the
//   entry at rptr whenever fifo2axi_ef=0. fifo2axi_rd pops that entry on the
//   rising edge, and is ignored while fifo2axi_ef=1.
//
// Ports
//   clkr, reset_clkr          clock, synchronous active-high reset
//   ul2fifo_vld/sop/eop/err   upstream beat valid, first, last, packet error
//   ul2fifo_mod[5:0]          invalid byte count on eop beat
//   ul2fifo_data[511:0]       beat payload
//   fifo2ul_rdy               upstream ready
//   fifo2axi_rd               pop the entry shown on fifo2axi_rdata
//   fifo2axi_rdata[539:0]     {20'b0, eop, err, mod[5:0], data[511:0]}
//   fifo2axi_ef               no committed entry available
//   fifo2axi_sop              the shown entry is the first beat of a packet
//   pkt_drop_cnt_en           error packet dropped (single-cycle pulse)
//   proto_err_cnt_en          sop/eop framing violation (single-cycle pulse)
//   ovf_cnt_en                packet larger than the FIFO dropped (pulse)
//   dbg_wr_state[1:0]         write-side FSM state (0 idle, 1 open, 2 drop)
// ----------------------------------------------------------------------------
module axi4_m512_pkt_fifo #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic         clkr,
  input  logic         reset_clkr,
  input  logic         ul2fifo_vld,
  input  logic         ul2fifo_sop,
  input  logic         ul2fifo_eop,
  input  logic         ul2fifo_err,
  input  logic [5:0]   ul2fifo_mod,
  input  logic [511:0] ul2fifo_data,
  output logic         fifo2ul_rdy,
  input  logic         fifo2axi_rd,
  output logic [539:0] fifo2axi_rdata,
  output logic         fifo2axi_ef,
  output logic         fifo2axi_sop,
  output logic         pkt_drop_cnt_en,
  output logic         proto_err_cnt_en,
  output logic         ovf_cnt_en,
  output logic [1:0]   dbg_wr_state
);

  localparam int PW    = ADDR_WIDTH + 1;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic [1:0] {
    WS_IDLE = 2'd0,  // between packets
    WS_OPEN = 2'd1,  // sop seen, eop not yet
    WS_DROP = 2'd2   // oversize packet: discard everything through eop
  } wr_state_t;

  logic [539:0]  mem [DEPTH];

  logic [PW-1:0] wptr, cptr, rptr;
  wr_state_t     wr_state;
  logic          pkt_start;
  logic          drop_q, proto_q, ovf_q;

  // write-side next-state signals
  wr_state_t     nxt_state;
  logic [PW-1:0] nxt_wptr, nxt_cptr;
  logic [PW-1:0] wr_addr, wr_addr_inc;
  logic          wr_en, wr_ok;
  logic          drop_nxt, proto_nxt, ovf_nxt;
  logic [539:0]  wr_data;

  logic          accept;
  logic          room;
  logic          ef_raw;
  logic          rd_fire;

  // ---------------------------------------------------------------- outputs
  // Occupancy counts uncommitted beats too, so a packet can never overwrite
  // committed entries the read side has not yet consumed.
  assign room        = (wptr - rptr) < DEPTH_P;
  // While dropping an oversize packet nothing is written, so accept freely.
  assign fifo2ul_rdy = ~reset_clkr & ((wr_state == WS_DROP) | room);
  assign accept      = ul2fifo_vld & fifo2ul_rdy;

  assign ef_raw         = (rptr == cptr);
  assign fifo2axi_ef    = reset_clkr | ef_raw;
  assign fifo2axi_sop   = ~reset_clkr & pkt_start & ~ef_raw;
  assign fifo2axi_rdata = mem[rptr[ADDR_WIDTH-1:0]];
  assign rd_fire        = fifo2axi_rd & ~fifo2axi_ef;

  assign pkt_drop_cnt_en  = drop_q  & ~reset_clkr;
  assign proto_err_cnt_en = proto_q & ~reset_clkr;
  assign ovf_cnt_en       = ovf_q   & ~reset_clkr;
  assign dbg_wr_state     = wr_state;

  assign wr_data = {20'd0, ul2fifo_eop, ul2fifo_err, ul2fifo_mod, ul2fifo_data};

  // ------------------------------------------------------ write-side FSM
  always_comb begin
    nxt_state   = wr_state;
    nxt_wptr    = wptr;
    nxt_cptr    = cptr;
    wr_en       = 1'b0;
    wr_ok       = 1'b0;
    wr_addr     = wptr;
    wr_addr_inc = wptr + PW'(1);
    drop_nxt    = 1'b0;
    proto_nxt   = 1'b0;
    ovf_nxt     = 1'b0;

    if (accept) begin
      case (wr_state)
        WS_DROP: begin
          if (ul2fifo_eop) nxt_state = WS_IDLE;
        end
        default: begin
          if (ul2fifo_sop) begin
            // sop while a packet is open: the open partial is abandoned and
            // the new packet starts over at the commit point.
            wr_ok     = 1'b1;
            proto_nxt = (wr_state == WS_OPEN);
            if (wr_state == WS_OPEN) wr_addr = cptr;
          end else if (wr_state == WS_IDLE) begin
            proto_nxt = 1'b1;    // continuation beat with no sop: dropped
          end else begin
            wr_ok = 1'b1;
          end

          if (wr_ok) begin
            wr_en       = 1'b1;
            wr_addr_inc = wr_addr + PW'(1);
            if (ul2fifo_eop) begin
              nxt_state = WS_IDLE;
`ifdef AXI4_M512_PKT_ERR_DROP_EN
              if (ul2fifo_err) begin
                nxt_wptr = cptr;
                drop_nxt = 1'b1;
              end else begin
                nxt_wptr = wr_addr_inc;
                nxt_cptr = wr_addr_inc;
              end
`else
              nxt_wptr = wr_addr_inc;
              nxt_cptr = wr_addr_inc;
`endif
            end else if ((wr_addr_inc - cptr) == DEPTH_P) begin
              // FIFO full of one unfinished packet: it can never commit.
              nxt_wptr  = cptr;
              nxt_state = WS_DROP;
              ovf_nxt   = 1'b1;
            end else begin
              nxt_wptr  = wr_addr_inc;
              nxt_state = WS_OPEN;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clkr) begin
    if (reset_clkr) begin
      wr_state  <= WS_IDLE;
      wptr      <= '0;
      cptr      <= '0;
      rptr      <= '0;
      pkt_start <= 1'b1;
      drop_q    <= 1'b0;
      proto_q   <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_state <= nxt_state;
      wptr     <= nxt_wptr;
      cptr     <= nxt_cptr;
      drop_q   <= drop_nxt;
      proto_q  <= proto_nxt;
      ovf_q    <= ovf_nxt;
      if (rd_fire) begin
        rptr      <= rptr + PW'(1);
        pkt_start <= fifo2axi_rdata[519];
      end
    end
  end

  // Storage carries no reset: entries are only visible below cptr.
  always_ff @(posedge clkr) begin
    if (wr_en) mem[wr_addr[ADDR_WIDTH-1:0]] <= wr_data;
  end

endmodule

// File: tb/tb_axi4_m512_pkt_fifo.sv
module tb_axi4_m512_pkt_fifo;

  logic         clkr = 1'b0;
  logic         reset_clkr;
  logic         ul2fifo_vld, ul2fifo_sop, ul2fifo_eop, ul2fifo_err;
  logic [5:0]   ul2fifo_mod;
  logic [511:0] ul2fifo_data;
  logic         fifo2ul_rdy;
  logic         fifo2axi_rd;
  logic [539:0] fifo2axi_rdata;
  logic         fifo2axi_ef, fifo2axi_sop;
  logic         pkt_drop_cnt_en, proto_err_cnt_en, ovf_cnt_en;
  logic [1:0]   dbg_wr_state;

  axi4_m512_pkt_fifo #(.ADDR_WIDTH(6)) dut (
    .clkr(clkr), .reset_clkr(reset_clkr),
    .ul2fifo_vld(ul2fifo_vld), .ul2fifo_sop(ul2fifo_sop),
    .ul2fifo_eop(ul2fifo_eop), .ul2fifo_err(ul2fifo_err),
    .ul2fifo_mod(ul2fifo_mod), .ul2fifo_data(ul2fifo_data),
    .fifo2ul_rdy(fifo2ul_rdy), .fifo2axi_rd(fifo2axi_rd),
    .fifo2axi_rdata(fifo2axi_rdata), .fifo2axi_ef(fifo2axi_ef),
    .fifo2axi_sop(fifo2axi_sop), .pkt_drop_cnt_en(pkt_drop_cnt_en),
    .proto_err_cnt_en(proto_err_cnt_en), .ovf_cnt_en(ovf_cnt_en),
    .dbg_wr_state(dbg_wr_state)
  );

  // ------------------------------------------------------ clock / reset
  always #5 clkr = ~clkr;

  // ------------------------------------------------------ scoreboard
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [539:0] exp_q[$];
  logic         mdl_start;     // expected sop flag of the next entry read
  logic         smp_ef;
  logic [2:0]   smp_pulse;     // {pkt_drop, proto_err, ovf}

  typedef struct {
    logic        vld, sop, eop, err;
    logic [5:0]  mod;
    logic [31:0] tag;
    logic        rd;
    logic        x_rdy, x_ef, x_sop;
    logic        chk_data;
    logic        x_eop, x_err;
    logic [5:0]  x_mod;
    logic [31:0] x_tag;
    logic [2:0]  x_pulse;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  function automatic logic [511:0] mk_data(input logic [31:0] tag);
    return {16{tag}};
  endfunction

  function automatic logic [539:0] mk_ent(input logic eop, input logic err,
                                          input logic [5:0] mod, input logic [31:0] tag);
    return {20'd0, eop, err, mod, mk_data(tag)};
  endfunction

  function automatic vec_t mkv(input logic vld, sop, eop, err, input logic [5:0] mod,
                               input logic [31:0] tag, input logic rd,
                               input logic x_rdy, x_ef, x_sop, chk_data, x_eop, x_err,
                               input logic [5:0] x_mod, input logic [31:0] x_tag,
                               input logic [2:0] x_pulse);
    vec_t v;
    v.vld = vld; v.sop = sop; v.eop = eop; v.err = err; v.mod = mod; v.tag = tag;
    v.rd = rd; v.x_rdy = x_rdy; v.x_ef = x_ef; v.x_sop = x_sop; v.chk_data = chk_data;
    v.x_eop = x_eop; v.x_err = x_err; v.x_mod = x_mod; v.x_tag = x_tag; v.x_pulse = x_pulse;
    return v;
  endfunction

  task automatic chk(input string name, input logic [539:0] act, input logic [539:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ------------------------------------------------------ driver tasks
  task automatic drive(input logic vld, sop, eop, err, input logic [5:0] mod,
                       input logic [31:0] tag, input logic rd);
    ul2fifo_vld  = vld;
    ul2fifo_sop  = sop;
    ul2fifo_eop  = eop;
    ul2fifo_err  = err;
    ul2fifo_mod  = mod;
    ul2fifo_data = mk_data(tag);
    fifo2axi_rd  = rd;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 6'd0, 32'd0, 0);
    reset_clkr = 1'b1;
    @(negedge clkr);
    chk("rst_rdy", fifo2ul_rdy, 0);
    chk("rst_ef", fifo2axi_ef, 1);
    chk("rst_sop", fifo2axi_sop, 0);
    chk("rst_pulses", {pkt_drop_cnt_en, proto_err_cnt_en, ovf_cnt_en}, 0);
    @(posedge clkr); #1;
    reset_clkr = 1'b0;
    exp_q.delete();
    mdl_start = 1'b1;
  endtask

  task automatic apply_row(input vec_t r, input int idx);
    drive(r.vld, r.sop, r.eop, r.err, r.mod, r.tag, r.rd);
    @(negedge clkr);
    chk($sformatf("row%0d_rdy", idx), fifo2ul_rdy, r.x_rdy);
    chk($sformatf("row%0d_ef", idx), fifo2axi_ef, r.x_ef);
    chk($sformatf("row%0d_sop", idx), fifo2axi_sop, r.x_sop);
    chk($sformatf("row%0d_pulse", idx),
        {pkt_drop_cnt_en, proto_err_cnt_en, ovf_cnt_en}, r.x_pulse);
    if (r.chk_data)
      chk($sformatf("row%0d_rdata", idx), fifo2axi_rdata,
          mk_ent(r.x_eop, r.x_err, r.x_mod, r.x_tag));
    @(posedge clkr); #1;
  endtask

  // One cycle: optional clean write (pushed to the scoreboard when push=1),
  // optional read checked against the scoreboard head.
  task automatic beat_cycle(input logic w, sop, eop, input logic [31:0] tag,
                            input logic push, input logic rd, input string nm);
    logic [539:0] e;
    logic [5:0]   m;
    m = eop ? tag[5:0] : 6'd0;
    drive(w, sop, eop, 0, m, tag, rd);
    @(negedge clkr);
    smp_ef    = fifo2axi_ef;
    smp_pulse = {pkt_drop_cnt_en, proto_err_cnt_en, ovf_cnt_en};
    if (w) begin
      chk({nm, "_rdy"}, fifo2ul_rdy, 1);
      if (push) exp_q.push_back(mk_ent(eop, 1'b0, m, tag));
    end
    if (rd && !fifo2axi_ef) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL %s_rd: entry %0h read, expected none", nm, fifo2axi_rdata);
      end else begin
        e = exp_q.pop_front();
        chk({nm, "_rdata"}, fifo2axi_rdata, e);
        chk({nm, "_sop"}, fifo2axi_sop, mdl_start);
        mdl_start = e[519];
      end
    end
    @(posedge clkr); #1;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 200 && exp_q.size() > 0; k++)
      beat_cycle(0, 0, 0, 32'd0, 0, 1, nm);
    chk({nm, "_drained"}, 540'(exp_q.size()), 0);
    drive(0, 0, 0, 0, 6'd0, 32'd0, 0);
    @(negedge clkr);
    chk({nm, "_ef_end"}, fifo2axi_ef, 1);
    @(posedge clkr); #1;
  endtask

  // ------------------------------------------------------ test
  initial begin
    int ovf_cnt, ef_low;

    // Basic 3-beat packet, read held high throughout.
    vecs[0]  = mkv(1,1,0,0,6'd0,32'hA0,1, 1,1,0, 0,0,0,6'd0,32'h0, 3'b000);
    vecs[1]  = mkv(1,0,0,0,6'd0,32'hA1,1, 1,1,0, 0,0,0,6'd0,32'h0, 3'b000);
    vecs[2]  = mkv(1,0,1,0,6'd4,32'hA2,1, 1,1,0, 0,0,0,6'd0,32'h0, 3'b000);
    vecs[3]  = mkv(0,0,0,0,6'd0,32'h0, 1, 1,0,1, 1,0,0,6'd0,32'hA0, 3'b000);
    vecs[4]  = mkv(0,0,0,0,6'd0,32'h0, 1, 1,0,0, 1,0,0,6'd0,32'hA1, 3'b000);
    vecs[5]  = mkv(0,0,0,0,6'd0,32'h0, 1, 1,0,0, 1,1,0,6'd4,32'hA2, 3'b000);
    vecs[6]  = mkv(0,0,0,0,6'd0,32'h0, 0, 1,1,0, 0,0,0,6'd0,32'h0, 3'b000);
    // sop, beat, sop again, eop: only the second packet survives.
    vecs[7]  = mkv(1,1,0,0,6'd0,32'hB0,0, 1,1,0, 0,0,0,6'd0,32'h0, 3'b000);
    vecs[8]  = mkv(1,0,0,0,6'd0,32'hB1,0, 1,1,0, 0,0,0,6'd0,32'h0, 3'b000);
    vecs[9]  = mkv(1,1,0,0,6'd0,32'hC0,0, 1,1,0, 0,0,0,6'd0,32'h0, 3'b000);
    vecs[10] = mkv(1,0,1,0,6'd0,32'hC1,0, 1,1,0, 0,0,0,6'd0,32'h0, 3'b010);
    vecs[11] = mkv(0,0,0,0,6'd0,32'h0, 1, 1,0,1, 1,0,0,6'd0,32'hC0, 3'b000);
    vecs[12] = mkv(0,0,0,0,6'd0,32'h0, 1, 1,0,0, 1,1,0,6'd0,32'hC1, 3'b000);
    // stray eop with no packet open is dropped; read on empty is ignored.
    vecs[13] = mkv(1,0,1,0,6'd0,32'hD0,1, 1,1,0, 0,0,0,6'd0,32'h0, 3'b000);
    vecs[14] = mkv(0,0,0,0,6'd0,32'h0, 1, 1,1,0, 0,0,0,6'd0,32'h0, 3'b010);
    vecs[15] = mkv(0,0,0,0,6'd0,32'h0, 0, 1,1,0, 0,0,0,6'd0,32'h0, 3'b000);
    // one-beat packet with err.
    vecs[16] = mkv(1,1,1,1,6'd5,32'hE0,0, 1,1,0, 0,0,0,6'd0,32'h0, 3'b000);
`ifdef AXI4_M512_PKT_ERR_DROP_EN
    vecs[17] = mkv(0,0,0,0,6'd0,32'h0, 0, 1,1,0, 0,0,0,6'd0,32'h0, 3'b100);
    vecs[18] = mkv(0,0,0,0,6'd0,32'h0, 1, 1,1,0, 0,0,0,6'd0,32'h0, 3'b000);
`else
    vecs[17] = mkv(0,0,0,0,6'd0,32'h0, 0, 1,0,1, 1,1,1,6'd5,32'hE0, 3'b000);
    vecs[18] = mkv(0,0,0,0,6'd0,32'h0, 1, 1,0,1, 1,1,1,6'd5,32'hE0, 3'b000);
`endif
    vecs[19] = mkv(0,0,0,0,6'd0,32'h0, 0, 1,1,0, 0,0,0,6'd0,32'h0, 3'b000);

    do_reset();
    for (int i = 0; i < NV; i++) apply_row(vecs[i], i);

    // Fill: 8 packets of 8 beats, no reads.
    do_reset();
    for (int i = 0; i < 64; i++)
      beat_cycle(1, (i % 8) == 0, (i % 8) == 7, 32'(100 + i), 1, 0, "fill");
    drive(0, 0, 0, 0, 6'd0, 32'd0, 0);
    @(negedge clkr);
    chk("fill_full_rdy", fifo2ul_rdy, 0);
    chk("fill_full_ef", fifo2axi_ef, 0);
    @(posedge clkr); #1;
    beat_cycle(0, 0, 0, 32'd0, 0, 1, "fill_rd");
    drive(0, 0, 0, 0, 6'd0, 32'd0, 0);
    @(negedge clkr);
    chk("fill_rdy_after_rd", fifo2ul_rdy, 1);
    @(posedge clkr); #1;
    drain("fill_rd");

    // Streaming writes and reads together; pointers wrap past 128.
    for (int p = 0; p < 30; p++)
      for (int b = 0; b < 3; b++)
        beat_cycle(1, b == 0, b == 2, 32'(500 + p * 3 + b), 1, 1, "strm");
    drain("strm");

    // Oversize packet: 70 beats into 64 entries.
    do_reset();
    ovf_cnt = 0;
    ef_low  = 0;
    for (int i = 0; i < 70; i++) begin
      beat_cycle(1, i == 0, i == 69, 32'(600 + i), 0, 0, "ovf");
      if (smp_pulse[0]) ovf_cnt++;
      if (!smp_ef) ef_low++;
    end
    beat_cycle(0, 0, 0, 32'd0, 0, 0, "ovf_idle");
    if (smp_pulse[0]) ovf_cnt++;
    if (!smp_ef) ef_low++;
    chk("ovf_pulse_count", 540'(ovf_cnt), 1);
    chk("ovf_ef_low_cycles", 540'(ef_low), 0);
    beat_cycle(1, 1, 0, 32'd700, 1, 0, "ovf_pkt");
    beat_cycle(1, 0, 1, 32'd701, 1, 0, "ovf_pkt");
    drain("ovf_pkt");

    // Reset in the middle of reading a 4-beat packet.
    do_reset();
    for (int i = 0; i < 4; i++)
      beat_cycle(1, i == 0, i == 3, 32'(800 + i), 1, 0, "mid");
    beat_cycle(0, 0, 0, 32'd0, 0, 1, "mid");
    beat_cycle(0, 0, 0, 32'd0, 0, 1, "mid");
    drive(0, 0, 0, 0, 6'd0, 32'd0, 1);
    reset_clkr = 1'b1;
    @(negedge clkr);
    chk("mid_rst_ef", fifo2axi_ef, 1);
    chk("mid_rst_sop", fifo2axi_sop, 0);
    chk("mid_rst_rdy", fifo2ul_rdy, 0);
    @(posedge clkr); #1;
    reset_clkr = 1'b0;
    drive(0, 0, 0, 0, 6'd0, 32'd0, 1);
    @(negedge clkr);
    chk("mid_after_ef", fifo2axi_ef, 1);
    chk("mid_after_sop", fifo2axi_sop, 0);
    chk("mid_after_rdy", fifo2ul_rdy, 1);
    @(posedge clkr); #1;
    exp_q.delete();
    mdl_start = 1'b1;
    beat_cycle(1, 1, 0, 32'd900, 1, 0, "post_rst");
    beat_cycle(1, 0, 1, 32'd901, 1, 0, "post_rst");
    drain("post_rst");

    // ---------------------------------------------------- report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
